// File: rtl/divider_pkg.sv
// Shared types and constants for the radix-2 restoring divider.
// The signed-operand variant is selected by the DIVIDER_SIGNED_EN macro in divider.sv.
package divider_pkg;

    localparam int unsigned DW1_DEF = 8;
    localparam int unsigned DW2_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam state_t STATE_RST = IDLE;
    localparam logic   FLAG_RST  = 1'b0;

    // Ceiling log2, evaluated at elaboration time.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (longint unsigned v = 1; v < longint'(n); v = v * 2) begin
            r++;
        end
        return r;
    endfunction

    // Iteration counter must hold DATA_WIDTH_1-1 and be at least one bit wide.
    function automatic int unsigned cnt_width(input int unsigned dw1);
        return (clog2(dw1) == 0) ? 1 : clog2(dw1);
    endfunction

endpackage

// File: rtl/divider_if.sv
// start/valid handshake bundle between a divider and its requester.
interface divider_if
    import divider_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_1 = DW1_DEF,
    parameter int unsigned DATA_WIDTH_2 = DW2_DEF
) ();

    logic                    start_i;
    logic [DATA_WIDTH_1-1:0] data1_i;
    logic [DATA_WIDTH_2-1:0] data2_i;
    logic                    busy_o;
    logic                    valid_o;
    logic [DATA_WIDTH_1-1:0] quotient_o;
    logic [DATA_WIDTH_2-1:0] remainder_o;
    logic                    dz_o;

    modport master (
        output start_i, data1_i, data2_i,
        input  busy_o, valid_o, quotient_o, remainder_o, dz_o
    );

    modport slave (
        input  start_i, data1_i, data2_i,
        output busy_o, valid_o, quotient_o, remainder_o, dz_o
    );

endinterface

// File: rtl/divider_step.sv
// One restoring division step: shift in a dividend bit, subtract the divisor if it fits.
module divider_step
    import divider_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_2 = DW2_DEF
) (
    input  logic [DATA_WIDTH_2-1:0] rem,
    input  logic                    dividend_bit,
    input  logic [DATA_WIDTH_2-1:0] divisor,
    output logic [DATA_WIDTH_2-1:0] next_rem_c,
    output logic                    q_bit_c
);

    logic [DATA_WIDTH_2:0] partial;
    logic [DATA_WIDTH_2:0] diff;

    // The extra MSB keeps the shifted remainder from overflowing before the compare.
    always_comb begin
        partial    = {rem, dividend_bit};
        diff       = partial - {1'b0, divisor};
        q_bit_c    = (partial >= {1'b0, divisor});
        next_rem_c = q_bit_c ? DATA_WIDTH_2'(diff) : DATA_WIDTH_2'(partial);
    end

endmodule

// File: rtl/divider.sv
// Sequential restoring radix-2 divider, one quotient bit per clock, start/valid handshake.
// Define DIVIDER_SIGNED_EN for two's-complement operands; default build is unsigned.
module divider
    import divider_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_1 = DW1_DEF,
    parameter int unsigned DATA_WIDTH_2 = DW2_DEF
) (
    input logic      clk,
    input logic      rst_n,
    divider_if.slave bus
);

    localparam int unsigned CNT_W = cnt_width(DATA_WIDTH_1);

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        count;
    logic [DATA_WIDTH_1-1:0] dvd;
    logic [DATA_WIDTH_2-1:0] rem;
    logic [DATA_WIDTH_2-1:0] dvs;
    logic                    dz;

    logic                    accept_c;
    logic                    div_zero_c;
    logic                    last_c;
    logic [DATA_WIDTH_1-1:0] mag1_c;
    logic [DATA_WIDTH_2-1:0] mag2_c;
    logic [DATA_WIDTH_2-1:0] step_rem_c;
    logic                    step_q_c;
    logic [DATA_WIDTH_1-1:0] q_fix_c;
    logic [DATA_WIDTH_2-1:0] r_fix_c;

    assign accept_c   = (state == IDLE) && bus.start_i;
    assign div_zero_c = (bus.data2_i == '0);
    assign last_c     = (count == '0);

    divider_step #(
        .DATA_WIDTH_2 (DATA_WIDTH_2)
    ) u_step (
        .rem          (rem),
        .dividend_bit (dvd[DATA_WIDTH_1-1]),
        .divisor      (dvs),
        .next_rem_c   (step_rem_c),
        .q_bit_c      (step_q_c)
    );

`ifdef DIVIDER_SIGNED_EN
    logic neg_q;
    logic neg_r;
    logic sign1_c;
    logic sign2_c;

    assign sign1_c = bus.data1_i[DATA_WIDTH_1-1];
    assign sign2_c = bus.data2_i[DATA_WIDTH_2-1];
    assign mag1_c  = sign1_c ? DATA_WIDTH_1'(-bus.data1_i) : bus.data1_i;
    assign mag2_c  = sign2_c ? DATA_WIDTH_2'(-bus.data2_i) : bus.data2_i;

    // Result signs: quotient by operand signs, remainder follows the dividend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= FLAG_RST;
            neg_r <= FLAG_RST;
        end else if (accept_c) begin
            neg_q <= sign1_c ^ sign2_c;
            neg_r <= sign1_c;
        end
    end

    // Divide-by-zero results bypass sign correction; most-negative/-1 wraps naturally.
    assign q_fix_c = (neg_q && !dz) ? DATA_WIDTH_1'(-dvd) : dvd;
    assign r_fix_c = (neg_r && !dz) ? DATA_WIDTH_2'(-rem) : rem;
`else
    assign mag1_c  = bus.data1_i;
    assign mag2_c  = bus.data2_i;
    assign q_fix_c = dvd;
    assign r_fix_c = rem;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STATE_RST;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start_i) begin
                    state_next = div_zero_c ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_c) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Working registers: dvd shifts dividend bits out and quotient bits in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            dvd   <= '0;
            rem   <= '0;
            dvs   <= '0;
            dz    <= FLAG_RST;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        count <= CNT_W'(DATA_WIDTH_1 - 1);
                        dvs   <= mag2_c;
                        dz    <= div_zero_c;
                        if (div_zero_c) begin
                            dvd <= '1;
                            rem <= DATA_WIDTH_2'(bus.data1_i);
                        end else begin
                            dvd <= mag1_c;
                            rem <= '0;
                        end
                    end
                end
                CALC: begin
                    dvd <= DATA_WIDTH_1'({dvd, step_q_c});
                    rem <= step_rem_c;
                    if (!last_c) begin
                        count <= count - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output registers; results hold until the next DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.valid_o     <= FLAG_RST;
            bus.busy_o      <= FLAG_RST;
            bus.dz_o        <= FLAG_RST;
            bus.quotient_o  <= '0;
            bus.remainder_o <= '0;
        end else begin
            bus.valid_o <= (state == DONE);
            bus.busy_o  <= (state_next == CALC);
            if (state == DONE) begin
                bus.quotient_o  <= q_fix_c;
                bus.remainder_o <= r_fix_c;
                bus.dz_o        <= dz;
            end
        end
    end

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Sequential unsigned integer divider; the inverse operation to the team's multiplier primitive.
- Restoring radix-2 algorithm: one quotient bit per clock.
- start/valid handshake, so it can feed or follow multiplier-based datapaths in the primitives library.
- Drivable from the MyHDL co-simulation flow like the other primitives.

Parameters:
- DATA_WIDTH_1, default 8: dividend width; also the quotient width.
- DATA_WIDTH_2, default 8: divisor width; also the remainder width.

Ports:
- clk, in, 1: single clock; all logic on rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- start_i, in, 1: request a division; sampled only in IDLE.
- data1_i, in, DATA_WIDTH_1: dividend; captured on the accepted start.
- data2_i, in, DATA_WIDTH_2: divisor; captured on the accepted start.
- busy_o, out, 1: high from the cycle after acceptance until valid_o; low in IDLE.
- valid_o, out, 1: one-cycle pulse; quotient_o, remainder_o and dz_o are valid.
- quotient_o, out, DATA_WIDTH_1: quotient.
- remainder_o, out, DATA_WIDTH_2: remainder.
- dz_o, out, 1: divide-by-zero flag; qualified by valid_o.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE.
  - busy_o=0, valid_o=0, dz_o=0.
  - quotient_o=0, remainder_o=0.
  - Internal counter and working registers cleared.
- Reset mid-operation aborts the division with no valid_o; the first start after release starts a fresh division.
- FSM IDLE:
  - start_i=1 latches operands.
  - Divisor != 0: go to CALC, count=DATA_WIDTH_1-1.
  - Divisor == 0: go to DONE directly.
- FSM CALC, each cycle:
  - Partial remainder (DATA_WIDTH_2+1 bits) = {rem, next dividend MSB}.
  - If partial >= divisor: subtract and shift in quotient bit 1; else shift in 0.
  - Decrement count; at count==0 go to DONE.
- FSM DONE: outputs registered, valid_o=1 for exactly one cycle, return to IDLE.
- Latency, start accepted at edge 0:
  - Normal: valid_o high in the cycle after edge DATA_WIDTH_1+1. The default width gives 9 cycles.
  - Divide-by-zero: valid_o high after edge 1.
- Throughput: a new start is accepted in the cycle after valid_o (IDLE). start_i in CALC/DONE is ignored, with no queuing.
- Outputs hold the last result until the next valid_o. dz_o is updated only at valid_o.
- Divide-by-zero: quotient_o = all ones, remainder_o = data1_i truncated to DATA_WIDTH_2 bits, dz_o=1.
- Result invariant: data1_i == quotient_o*data2_i + remainder_o, with remainder_o < data2_i for any nonzero divisor.
- Inputs data1_i/data2_i may change freely after acceptance; the result is unaffected.

Optional Feature:
- Macro: DIVIDER_SIGNED_EN.
- Defined: operands are two's complement.
  - Magnitudes are taken at load; the same unsigned core runs.
  - Signs are fixed in DONE.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Overflow: most-negative / -1 yields quotient = most-negative, remainder 0, dz_o=0.
  - Divide-by-zero: quotient all ones (-1), remainder = dividend truncated, dz_o=1.
  - Latency unchanged.
- Undefined: pure unsigned behaviour as above; no sign logic synthesised.

Decomposition:
- Package divider_pkg holds:
  - State encoding typedef (IDLE, CALC, DONE).
  - Counter-width function clog2(DATA_WIDTH_1).
  - Reset-value constants.
- Sub-module divider_step: combinational single restoring step.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
- divider instantiates one divider_step and owns the FSM, counter and output registers.

Test Plan:
- Reset then start with 34/22 -> valid_o after 9 cycles; quotient 1, remainder 12, dz_o 0; busy_o high for 8 cycles before valid_o.
- Back-to-back 99/9 then 9/99, second start in the cycle after valid_o -> 11 r 0, then 0 r 9; both accepted.
- 255/1 and 255/255 -> 255 r 0 and 1 r 0; check no overflow in the partial-remainder MSB with 200/201 -> 0 r 200.
- 77/0 -> valid_o after 1 cycle; quotient 255, remainder 77, dz_o 1. Next op 77/7 -> 11 r 0 with dz_o back to 0.
- start_i pulsed with 50/5 during CALC of 34/22 -> ignored; only 1 r 12 is reported; busy_o stays asserted.
- rst_n low for 1 cycle at count 4 of 99/9 -> all outputs 0, no valid_o. Then 99/9 -> 11 r 0. With DIVIDER_SIGNED_EN also -34/22 -> -1 r -12, and -128/-1 -> -128 r 0.
